// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: decode-side request bus and result/stall return for muldiv_unit.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             mul_en;
  logic             div_en;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             stall;
  logic             valid;
  logic [WIDTH-1:0] result;

  // Pipeline side: issues requests, observes stall and result.
  modport master (
    output mul_en, div_en, funct3, src_a, src_b, flush,
    input  stall, valid, result
  );

  // Unit side: consumes requests, produces stall and result.
  modport slave (
    input  mul_en, div_en, funct3, src_a, src_b, flush,
    output stall, valid, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide for the execute stage.
// One multiplier/quotient bit per cycle on magnitudes; signs are fixed up
// on the final cycle. Divide-by-zero and signed overflow skip the iterations.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               op_div_q, op_div_d;
  logic [1:0]         op_sel_q, op_sel_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic               req_s, accept_s;
  logic               a_signed_s, b_signed_s, sign_a_s, sign_b_s;
  logic [WIDTH-1:0]   abs_a_s, abs_b_s;
  logic               div_zero_s, div_ovf_s;
  logic [WIDTH-1:0]   special_res_s;
  logic [WIDTH:0]     mul_sum_s, rem_ext_s, div_sub_s;
  logic               div_ge_s;
  logic [WIDTH-1:0]   div_rem_s;
  logic [2*WIDTH-1:0] step_acc_s, prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s, final_res_s;
  logic               unused_s;

  // funct3[2] only distinguishes mul/div, which mul_en/div_en already carry.
  assign unused_s = ^{bus.funct3[2], div_sub_s[WIDTH]};

  // Request decode, operand signedness/magnitude and special-case results.
  always_comb begin
    req_s      = bus.mul_en | bus.div_en;
    accept_s   = (state_q == ST_IDLE) & req_s & ~bus.flush;
    a_signed_s = 1'b0;
    b_signed_s = 1'b0;
    if (bus.div_en) begin
      a_signed_s = ~bus.funct3[0];
      b_signed_s = ~bus.funct3[0];
    end else begin
      case (bus.funct3[1:0])
        2'b01:   begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
        2'b10:   begin a_signed_s = 1'b1; b_signed_s = 1'b0; end
        default: begin a_signed_s = 1'b0; b_signed_s = 1'b0; end
      endcase
    end
    sign_a_s   = a_signed_s & bus.src_a[WIDTH-1];
    sign_b_s   = b_signed_s & bus.src_b[WIDTH-1];
    abs_a_s    = sign_a_s ? -bus.src_a : bus.src_a;
    abs_b_s    = sign_b_s ? -bus.src_b : bus.src_b;
    div_zero_s = bus.div_en & (bus.src_b == ZERO);
    div_ovf_s  = bus.div_en & ~bus.funct3[0] & (bus.src_a == MIN_NEG) & (bus.src_b == ALL_ONES);
    if (div_zero_s) begin
      special_res_s = bus.funct3[1] ? bus.src_a : ALL_ONES;
    end else begin
      special_res_s = bus.funct3[1] ? ZERO : MIN_NEG;
    end
  end

  // One shift-add or restoring-subtract step, plus sign fix-up of the result.
  always_comb begin
    mul_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (opb_q[0] ? {1'b0, opa_q} : {(WIDTH+1){1'b0}});
    rem_ext_s = {acc_q[2*WIDTH-1:WIDTH], opa_q[WIDTH-1]};
    div_ge_s  = (rem_ext_s >= {1'b0, opb_q});
    div_sub_s = rem_ext_s - {1'b0, opb_q};
    div_rem_s = div_ge_s ? div_sub_s[WIDTH-1:0] : rem_ext_s[WIDTH-1:0];
    if (op_div_q) begin
      step_acc_s = {div_rem_s, acc_q[WIDTH-2:0], div_ge_s};
    end else begin
      step_acc_s = {mul_sum_s, acc_q[WIDTH-1:1]};
    end
    prod_s = neg_quo_q ? -step_acc_s : step_acc_s;
    quo_s  = neg_quo_q ? -step_acc_s[WIDTH-1:0] : step_acc_s[WIDTH-1:0];
    rem_s  = neg_rem_q ? -step_acc_s[2*WIDTH-1:WIDTH] : step_acc_s[2*WIDTH-1:WIDTH];
    if (op_div_q) begin
      final_res_s = op_sel_q[1] ? rem_s : quo_s;
    end else if (op_sel_q == 2'b00) begin
      final_res_s = prod_s[WIDTH-1:0];
    end else begin
      final_res_s = prod_s[2*WIDTH-1:WIDTH];
    end
  end

  // Next-state logic: accept, iterate, present result, flush.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    op_div_d  = op_div_q;
    op_sel_d  = op_sel_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    valid_d   = 1'b0;
    result_d  = result_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          op_div_d  = bus.div_en;
          op_sel_d  = bus.funct3[1:0];
          opa_d     = abs_a_s;
          opb_d     = abs_b_s;
          neg_quo_d = sign_a_s ^ sign_b_s;
          neg_rem_d = sign_a_s;
          acc_d     = {(2*WIDTH){1'b0}};
          if (div_zero_s || div_ovf_s) begin
            result_d = special_res_s;
            valid_d  = 1'b1;
            state_d  = ST_DONE;
          end else begin
            cnt_d   = CNT_LAST;
            state_d = ST_BUSY;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = step_acc_s;
          if (op_div_q) begin
            opa_d = {opa_q[WIDTH-2:0], 1'b0};
          end else begin
            opb_d = {1'b0, opb_q[WIDTH-1:1]};
          end
          if (cnt_q == CNT_ZERO) begin
            result_d = final_res_s;
            valid_d  = 1'b1;
            state_d  = ST_DONE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= CNT_ZERO;
      acc_q     <= {(2*WIDTH){1'b0}};
      opa_q     <= ZERO;
      opb_q     <= ZERO;
      op_div_q  <= 1'b0;
      op_sel_q  <= 2'b00;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      valid_q   <= 1'b0;
      result_q  <= ZERO;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      op_div_q  <= op_div_d;
      op_sel_q  <= op_sel_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      valid_q   <= valid_d;
      result_q  <= result_d;
    end
  end

  // Stall drops immediately on flush; valid is killed by a flush in DONE.
  assign bus.stall  = rst_n & (accept_s | ((state_q == ST_BUSY) & ~bus.flush));
  assign bus.valid  = valid_q & ~bus.flush;
  assign bus.result = result_q;
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multi-cycle multiply/divide unit in the execute stage. It consumes the `mul_en` / `div_en` strobes and funct3 produced by instruction decode, and computes the RV32M result. While busy it holds the pipeline through a stall output. When the result is ready it presents it for exactly one cycle, so the execute-stage instruction can advance with its result.

## Interface

- `WIDTH`, 32, operand/result width (iteration count equals `WIDTH`)

Ports:

- `clk`, input, 1: clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `mul_en`, input, 1: execute-stage instruction is a multiply-family op.
- `div_en`, input, 1: execute-stage instruction is a divide-family op.
- `funct3`, input, 3: RV32M funct3. Only `[1:0]` is used.
- `src_a`, input, `WIDTH`: rs1 operand (forwarded value).
- `src_b`, input, `WIDTH`: rs2 operand (forwarded value).
- `flush`, input, 1: kill the in-flight operation (branch mispredict / jump).
- `stall`, output, 1: hold the fetch, decode and execute stages.
- `valid`, output, 1: `result` is valid this cycle.
- `result`, output, `WIDTH`: selected product half, quotient, or remainder.

## Operation

- **Request:** `req = mul_en | div_en`. If both are high, `div_en` wins (illegal from decode).
- **Op select (mul, by `funct3[1:0]`):**
  - 00 MUL: low word.
  - 01 MULH: signed×signed, high word.
  - 10 MULHSU: signed `src_a` × unsigned `src_b`, high word.
  - 11 MULHU: unsigned×unsigned, high word.
- **Op select (div, by `funct3[1:0]`):**
  - 00 DIV: signed quotient.
  - 01 DIVU: unsigned quotient.
  - 10 REM: signed remainder.
  - 11 REMU: unsigned remainder.
- **States:**
  - IDLE: no operation in progress.
  - BUSY: 32 iterations, with `iter_cnt` counting `WIDTH-1` down to 0.
  - DONE: result presented for one cycle.
- **Transitions:**
  - IDLE → BUSY on `req & ~flush` with no special case.
  - IDLE → DONE on `req & ~flush` with a special case.
  - BUSY → DONE when `iter_cnt == 0`.
  - DONE → IDLE always.
  - Any state → IDLE on `flush`.
- **Accept (IDLE):**
  - Latch the absolute values of signed operands, the result-sign flags, and the op.
  - Clear the 2×`WIDTH` accumulator / partial remainder.
- **Multiply:** unsigned shift-add, one multiplier bit per cycle, 2×`WIDTH`-bit product. Two's-complement negate the full product if `sign_a ^ sign_b` (signed modes only).
- **Divide:** restoring division, one quotient bit per cycle, `WIDTH+1`-bit trial subtraction.
  - Quotient negated if `sign_a ^ sign_b`.
  - Remainder takes the sign of the dividend.
- **Special cases (no iteration, result in DONE):**
  - Divide by zero: quotient = all-ones, remainder = `src_a`, for both signed and unsigned.
  - Signed overflow (`src_a` = 0x80000000, `src_b` = 0xFFFFFFFF, DIV/REM): quotient = 0x80000000, remainder = 0.
- **Operand capture:** operands are sampled only at accept. Later changes on `src_a`/`src_b`/`funct3` have no effect until the next accept.
- **Retrigger guard:** `req` stays high while the same instruction sits in execute. DONE ignores `req`, and the next accept happens in IDLE after the instruction advances.

## Timing

- **Reset values:** state = IDLE, `stall` = 0, `valid` = 0, `result` = 0, `iter_cnt` = 0, accumulator = 0.
- **Reset mid-operation:** returns to IDLE immediately with outputs at reset values and no `valid` pulse.
- **`stall`** (combinational) = `(state==IDLE & req & ~flush) | state==BUSY`. It is low in DONE.
- **Normal latency:** accept in cycle 0, BUSY in cycles 1–32, DONE in cycle 33.
  - `stall` is high in cycles 0–32.
  - `valid` is high in cycle 33 only.
- **Special-case latency:** accept in cycle 0, DONE in cycle 1.
  - `stall` is high in cycle 0.
  - `valid` is high in cycle 1.
- **Outputs:** `valid` and `result` are registered. `result` holds its last value after DONE and is don't-care when `valid` = 0.
- **`flush`:**
  - In BUSY: next state is IDLE, `stall` drops the same cycle, and no `valid` is produced.
  - Coincident with DONE: `valid` is suppressed.
  - In IDLE: `flush` blocks accept.
- **Back-to-back ops:** the earliest next accept is the cycle after DONE, giving a minimum 34-cycle issue interval.

## Test plan

- **MUL:** `mul_en`, funct3=000, 7 × 0xFFFFFFFD → `stall` high cycles 0–32; `valid` in cycle 33 with `result` = 0xFFFFFFEB.
- **MULHU / MULH:**
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULH of the same operands → 0x00000000.
  - MULHSU 0xFFFFFFFF × 0x00000002 → 0xFFFFFFFF.
- **DIV/REM:**
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD.
  - REM → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14; REMU → 2.
- **Special cases:**
  - DIV 5 / 0 → 0xFFFFFFFF.
  - REMU 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
  - All with `valid` in cycle 1 and `stall` high only in cycle 0.
- **Flush and reset mid-operation:**
  - `flush` at cycle 10 → `stall` low at cycle 10, no `valid`, IDLE at cycle 11.
  - `rst_n` low at cycle 20 → all outputs 0 asynchronously.
  - A fresh request afterwards completes correctly.
- **Held `req` through DONE:** no second operation starts. A new op with `req` reasserted the cycle after DONE is accepted and produces a correct `valid` 33 cycles later.
